// File: rtl/wt_dcache_rd_arb.sv
// Read/word-write arbiter for the write-through L1 dcache tag/data arrays.
// Two-class round-robin with starvation promotion; refills always win.
module wt_dcache_rd_arb #(
  parameter int unsigned NumPorts    = 3,
  parameter int unsigned IdxWidth    = 8,
  parameter int unsigned OffWidth    = 4,
  parameter int unsigned TagWidth    = 16,
  parameter int unsigned StarveLimit = 15
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumPorts-1:0]                rd_req_i,
  input  logic [NumPorts-1:0]                rd_prio_i,
  input  logic [NumPorts-1:0]                rd_tag_only_i,
  input  logic [NumPorts-1:0][IdxWidth-1:0]  rd_idx_i,
  input  logic [NumPorts-1:0][OffWidth-1:0]  rd_off_i,
  input  logic [NumPorts-1:0][TagWidth-1:0]  rd_tag_i,
  output logic [NumPorts-1:0]                rd_ack_o,
  input  logic                               wr_cl_vld_i,
  input  logic                               wr_req_i,
  output logic                               wr_ack_o,
  output logic                               arr_rd_en_o,
  output logic                               arr_rd_tag_only_o,
  output logic [IdxWidth-1:0]                arr_rd_idx_o,
  output logic [OffWidth-1:0]                arr_rd_off_o,
  output logic                               rsp_vld_o,
  output logic [NumPorts-1:0]                rsp_port_o,
  output logic [TagWidth-1:0]                rsp_tag_o,
  output logic                               rsp_tag_only_o
);

  localparam int unsigned PtrWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned CntWidth = 8;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(StarveLimit);

  // First requester at or after ptr, wrapping at NumPorts-1.
  function automatic logic [NumPorts-1:0] rr_pick(input logic [NumPorts-1:0] req,
                                                   input logic [PtrWidth-1:0] ptr);
    logic [NumPorts-1:0] gnt;
    logic                found;
    int unsigned         p;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      p = (32'(ptr) + k) % NumPorts;
      if (!found && ((req & (NumPorts'(1) << p)) != '0)) begin
        gnt   = NumPorts'(1) << p;
        found = 1'b1;
      end
    end
    return gnt;
  endfunction

  logic [PtrWidth-1:0] r_h_ptr, r_l_ptr;
  logic [CntWidth-1:0] r_starve_cnt;

  logic [NumPorts-1:0] w_h, w_l, w_h_gnt, w_l_gnt, w_gnt;
  logic                w_promote, w_sel_h, w_sel_l;
  logic [IdxWidth-1:0] w_idx;
  logic [OffWidth-1:0] w_off;
  logic [TagWidth-1:0] w_tag;
  logic                w_tag_only;
  logic [PtrWidth-1:0] w_gnt_idx, w_nxt_ptr;

  assign w_h       = rd_req_i & rd_prio_i;
  assign w_l       = rd_req_i & ~rd_prio_i;
  assign w_promote = (r_starve_cnt == CntMax);
  assign w_h_gnt   = rr_pick(w_h, r_h_ptr);
  assign w_l_gnt   = rr_pick(w_l, r_l_ptr);

  // Class selection: refill/reset block everything, then promoted L, H, L.
  always_comb begin
    w_sel_h = 1'b0;
    w_sel_l = 1'b0;
    if (!rst_i && !wr_cl_vld_i) begin
      if (w_promote && (w_l != '0)) w_sel_l = 1'b1;
      else if (w_h != '0)           w_sel_h = 1'b1;
      else if (w_l != '0)           w_sel_l = 1'b1;
    end
  end

  assign w_gnt = w_sel_l ? w_l_gnt : (w_sel_h ? w_h_gnt : '0);

  always_comb begin
    w_idx      = '0;
    w_off      = '0;
    w_tag      = '0;
    w_tag_only = 1'b0;
    w_gnt_idx  = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (w_gnt[i]) begin
        w_idx      = w_idx | rd_idx_i[i];
        w_off      = w_off | rd_off_i[i];
        w_tag      = w_tag | rd_tag_i[i];
        w_tag_only = w_tag_only | rd_tag_only_i[i];
        w_gnt_idx  = w_gnt_idx | PtrWidth'(i);
      end
    end
  end

  assign w_nxt_ptr = (w_gnt_idx == PtrWidth'(NumPorts - 1)) ? '0 : w_gnt_idx + PtrWidth'(1);

  assign rd_ack_o          = w_gnt;
  assign arr_rd_en_o       = (w_gnt != '0);
  assign arr_rd_tag_only_o = w_tag_only;
  assign arr_rd_idx_o      = w_idx;
  assign arr_rd_off_o      = w_off;
  // A tag-only read leaves the data bank free for the word write.
  assign wr_ack_o = !rst_i && wr_req_i && !wr_cl_vld_i && (!arr_rd_en_o || w_tag_only);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_h_ptr        <= '0;
      r_l_ptr        <= '0;
      r_starve_cnt   <= '0;
      rsp_vld_o      <= 1'b0;
      rsp_port_o     <= '0;
      rsp_tag_o      <= '0;
      rsp_tag_only_o <= 1'b0;
    end else begin
      rsp_vld_o      <= arr_rd_en_o;
      rsp_port_o     <= w_gnt;
      rsp_tag_o      <= w_tag;
      rsp_tag_only_o <= w_tag_only;
      if (w_sel_h) r_h_ptr <= w_nxt_ptr;
      if (w_sel_l) r_l_ptr <= w_nxt_ptr;
      // Starvation counter frozen during refills.
      if (!wr_cl_vld_i) begin
        if ((w_l == '0) || w_sel_l)  r_starve_cnt <= '0;
        else if (r_starve_cnt != CntMax) r_starve_cnt <= r_starve_cnt + CntWidth'(1);
      end
    end
  end

endmodule
